hybrid_control_sequencer: RTL and testbench
===========================================

# hybrid_control_sequencer

Start-up, shutdown and fault sequencer for the LLC hybrid controller. It owns the angle commands (theta, phi) that feed the hybrid jump-set controller and rate-limits them during soft-start, run and soft-stop. It holds the controller's automaton in reset while idle and gates the four MOSFET commands it returns. It sits between the supervisory/UI logic (enable, references, fault) and the hybrid control block.

## Interface
Parameters:
- THETA_START, 170, theta (degrees) applied in IDLE/STOP end-point; soft-start begins here
- THETA_MIN, 90, lower clamp for theta reference
- THETA_MAX, 179, upper clamp for theta reference
- PHI_MAX, 60, upper clamp for phi reference (lower clamp 0)
- STEP, 1, angle increment (degrees) per ramp tick
- RAMP_DIV, 5000, clock cycles per ramp tick (≥1)
- PRE_CYCLES, 1000, cycles in PRECHARGE (≥1)

Ports:
- i_clock  in  1  system clock
- i_RESET  in  1  asynchronous active-low reset
- i_enable  in  1  level; 1 = run converter
- i_fault  in  1  level; overcurrent/overvoltage fault
- i_clear  in  1  single-cycle fault acknowledge
- i_theta_ref  in  32 signed  target theta, degrees
- i_phi_ref  in  32 signed  target phi, degrees
- i_MOSFET  in  4  MOSFET commands from hybrid control
- o_theta  out  32 signed  theta to hybrid control
- o_phi  out  32 signed  phi to hybrid control
- o_RESET_ctrl  out  1  active-low reset to hybrid control
- o_MOSFET  out  4  gated MOSFET commands
- o_ready  out  1  1 while in RUN
- o_state  out  3  state code for debug

## Operation
- States/codes: IDLE=0, PRECHARGE=1, RAMP=2, RUN=3, STOP=4, FAULT=5.
- Clamped refs: th_r = clamp(i_theta_ref, THETA_MIN, THETA_MAX); ph_r = clamp(i_phi_ref, 0, PHI_MAX); signed 32-bit compares.
- Ramp tick: prescaler counts 0..RAMP_DIV-1, tick on RAMP_DIV-1, cleared on every state change. Step rule per tick: if |target−cur| ≤ STEP then cur = target, else cur ± STEP toward target.
- IDLE: o_theta=THETA_START, o_phi=0, o_RESET_ctrl=0, gates off. i_enable=1 → PRECHARGE.
- PRECHARGE: o_RESET_ctrl=1, gates off, angles held. After PRE_CYCLES cycles → RAMP. i_enable=0 → IDLE.
- RAMP: gates on. theta steps toward th_r; phi held at 0 until theta==th_r, then phi steps toward ph_r. Both equal → RUN. i_enable=0 → STOP.
- RUN: o_ready=1; theta and phi each step toward th_r/ph_r on the same tick, independently. i_enable=0 → STOP.
- STOP: gates on. phi steps to 0 first, then theta steps to THETA_START. Both reached → IDLE. i_enable=1 → RAMP, with angles continuing from their current values.
- FAULT (entered from any state while i_fault=1; highest priority): gates off, o_RESET_ctrl=0, angles forced to THETA_START/0. Sticky. Exits to IDLE only on a cycle with i_clear=1 and i_fault=0. i_clear is ignored in other states.
- Gating: o_MOSFET = i_MOSFET & {4{gate_en & ~i_fault}}. gate_en=1 in RAMP/RUN/STOP.

## Timing
- Reset (async, i_RESET=0): state IDLE, o_theta=THETA_START, o_phi=0, o_RESET_ctrl=0, o_MOSFET=0, o_ready=0, o_state=0, prescaler=0.
- All outputs except o_MOSFET are registered; state change is visible on the cycle after the triggering input.
- o_MOSFET is combinational from i_MOSFET and i_fault. Fault cuts gates in the same cycle; gate_en follows state with 1-cycle latency.
- PRECHARGE lasts exactly PRE_CYCLES cycles: entry cycle is counted as 1.
- First angle step lands RAMP_DIV cycles after RAMP entry.
- Simultaneous events: i_fault beats everything. i_enable drop beats the ramp-complete condition (RAMP→STOP). A ref change mid-ramp retargets on the next tick.
- Reset mid-operation returns to the reset values immediately, regardless of state.

## Test plan
- Parameters THETA_START=170, STEP=1, RAMP_DIV=4, PRE_CYCLES=8, i_theta_ref=160, i_phi_ref=5. Raise i_enable → o_RESET_ctrl=1 next cycle; gates open after 8 cycles; theta reaches 160 after 40 cycles of RAMP, then phi reaches 5 after 20 more; o_ready=1, o_state=3.
- In RUN, drop i_enable → phi decrements every 4 cycles to 0, then theta increments to 170 → IDLE, o_RESET_ctrl=0, o_MOSFET=0.
- i_theta_ref=45, i_phi_ref=−10 → o_theta settles at 90, o_phi stays 0 (clamps).
- Assert i_fault in RUN with i_MOSFET=4'b1001 → o_MOSFET=0 in the same cycle; o_state=5 next cycle. An i_clear pulse while i_fault=1 has no effect; with i_fault=0 it returns to IDLE.
- i_enable toggled 1→0→1 during STOP at theta=165 → RAMP resumes from 165, no jump.
- Async i_RESET low mid-RAMP with o_theta=163 → o_theta=170, o_state=0 without waiting for a clock edge.

Source files
------------

// File: rtl/hybrid_control_sequencer.sv
// Start-up / shutdown / fault sequencer for the LLC hybrid controller.
// Rate-limits theta/phi, holds the controller in reset and gates MOSFETs.
module hybrid_control_sequencer #(
    parameter int THETA_START = 170,
    parameter int THETA_MIN   = 90,
    parameter int THETA_MAX   = 179,
    parameter int PHI_MAX     = 60,
    parameter int STEP        = 1,
    parameter int RAMP_DIV    = 5000,
    parameter int PRE_CYCLES  = 1000
) (
    input  logic               i_clock,
    input  logic               i_RESET,
    input  logic               i_enable,
    input  logic               i_fault,
    input  logic               i_clear,
    input  logic signed [31:0] i_theta_ref,
    input  logic signed [31:0] i_phi_ref,
    input  logic [3:0]         i_MOSFET,
    output logic signed [31:0] o_theta,
    output logic signed [31:0] o_phi,
    output logic               o_RESET_ctrl,
    output logic [3:0]         o_MOSFET,
    output logic               o_ready,
    output logic [2:0]         o_state
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRECHARGE = 3'd1,
        RAMP      = 3'd2,
        RUN       = 3'd3,
        STOP      = 3'd4,
        FAULT     = 3'd5
    } state_t;

    localparam logic signed [31:0] TH_START = THETA_START;
    localparam logic signed [31:0] TH_MIN   = THETA_MIN;
    localparam logic signed [31:0] TH_MAX   = THETA_MAX;
    localparam logic signed [31:0] PH_MAX   = PHI_MAX;
    localparam logic signed [31:0] STP      = STEP;
    localparam logic signed [31:0] ZERO     = '0;
    localparam logic [31:0]        DIV_LAST = 32'(RAMP_DIV - 1);
    localparam logic [31:0]        PRE_LAST = 32'(PRE_CYCLES - 1);

    state_t             state_q, state_d;
    logic [31:0]        presc_q;
    logic [31:0]        pre_q;
    logic signed [31:0] theta_q, theta_d;
    logic signed [31:0] phi_q, phi_d;
    logic signed [31:0] th_r, ph_r;
    logic               rst_ctrl_q;
    logic               ready_q;
    logic               tick;
    logic               gate_en;

    function automatic logic signed [31:0] step_to(
        input logic signed [31:0] cur,
        input logic signed [31:0] tgt
    );
        logic signed [31:0] diff;
        diff = tgt - cur;
        if (diff <= STP && diff >= -STP) step_to = tgt;
        else if (diff > ZERO)            step_to = cur + STP;
        else                             step_to = cur - STP;
    endfunction

    always_comb begin
        th_r = i_theta_ref;
        if (i_theta_ref < TH_MIN)      th_r = TH_MIN;
        else if (i_theta_ref > TH_MAX) th_r = TH_MAX;
        ph_r = i_phi_ref;
        if (i_phi_ref < ZERO)          ph_r = ZERO;
        else if (i_phi_ref > PH_MAX)   ph_r = PH_MAX;
    end

    assign tick = (presc_q == DIV_LAST);

    always_comb begin
        state_d = state_q;
        if (i_fault) begin
            state_d = FAULT;
        end else begin
            unique case (state_q)
                IDLE:
                    if (i_enable) state_d = PRECHARGE;
                PRECHARGE:
                    if (!i_enable)            state_d = IDLE;
                    else if (pre_q == PRE_LAST) state_d = RAMP;
                RAMP:
                    if (!i_enable) state_d = STOP;
                    else if (theta_q == th_r && phi_q == ph_r) state_d = RUN;
                RUN:
                    if (!i_enable) state_d = STOP;
                STOP:
                    if (i_enable) state_d = RAMP;
                    else if (phi_q == ZERO && theta_q == TH_START) state_d = IDLE;
                FAULT:
                    if (i_clear) state_d = IDLE;
                default:
                    state_d = IDLE;
            endcase
        end
    end

    // STOP unwinds phi before theta; RAMP winds theta before phi.
    always_comb begin
        theta_d = theta_q;
        phi_d   = phi_q;
        if (state_d == FAULT || state_d == IDLE) begin
            theta_d = TH_START;
            phi_d   = ZERO;
        end else if (tick) begin
            case (state_q)
                RAMP:
                    if (theta_q != th_r) theta_d = step_to(theta_q, th_r);
                    else                 phi_d   = step_to(phi_q, ph_r);
                RUN: begin
                    theta_d = step_to(theta_q, th_r);
                    phi_d   = step_to(phi_q, ph_r);
                end
                STOP:
                    if (phi_q != ZERO) phi_d   = step_to(phi_q, ZERO);
                    else               theta_d = step_to(theta_q, TH_START);
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clock or negedge i_RESET) begin
        if (!i_RESET) begin
            state_q    <= IDLE;
            presc_q    <= '0;
            pre_q      <= '0;
            theta_q    <= TH_START;
            phi_q      <= ZERO;
            rst_ctrl_q <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q || tick) presc_q <= '0;
            else                            presc_q <= presc_q + 32'd1;
            if (state_d != state_q)         pre_q <= '0;
            else if (state_q == PRECHARGE)  pre_q <= pre_q + 32'd1;
            theta_q    <= theta_d;
            phi_q      <= phi_d;
            rst_ctrl_q <= (state_d != IDLE) && (state_d != FAULT);
            ready_q    <= (state_d == RUN);
        end
    end

    assign gate_en      = (state_q == RAMP) || (state_q == RUN) || (state_q == STOP);
    assign o_MOSFET     = i_MOSFET & {4{gate_en & ~i_fault}};
    assign o_theta      = theta_q;
    assign o_phi        = phi_q;
    assign o_RESET_ctrl = rst_ctrl_q;
    assign o_ready      = ready_q;
    assign o_state      = state_q;

endmodule

// File: tb/tb_hybrid_control_sequencer.sv
// Directed bench for hybrid_control_sequencer (RAMP_DIV=4, PRE_CYCLES=8).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_hybrid_control_sequencer;

    logic               clk;
    logic               rst_n;
    logic               en;
    logic               flt;
    logic               clr;
    logic signed [31:0] th_ref;
    logic signed [31:0] ph_ref;
    logic [3:0]         mos_in;
    logic signed [31:0] theta;
    logic signed [31:0] phi;
    logic               rst_ctrl;
    logic [3:0]         mos_out;
    logic               ready;
    logic [2:0]         state;

    int tests;
    int failed;

    hybrid_control_sequencer #(
        .THETA_START(170),
        .THETA_MIN  (90),
        .THETA_MAX  (179),
        .PHI_MAX    (60),
        .STEP       (1),
        .RAMP_DIV   (4),
        .PRE_CYCLES (8)
    ) dut (
        .i_clock     (clk),
        .i_RESET     (rst_n),
        .i_enable    (en),
        .i_fault     (flt),
        .i_clear     (clr),
        .i_theta_ref (th_ref),
        .i_phi_ref   (ph_ref),
        .i_MOSFET    (mos_in),
        .o_theta     (theta),
        .o_phi       (phi),
        .o_RESET_ctrl(rst_ctrl),
        .o_MOSFET    (mos_out),
        .o_ready     (ready),
        .o_state     (state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step_n(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b1; en = 1'b0; flt = 1'b0; clr = 1'b0;
        th_ref = 160; ph_ref = 5; mos_in = 4'hF;
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (theta !== 32'sd170) begin failed++; $display("FAIL rst_theta: got %0d want 170", theta); end
        tests++;
        if (phi !== 32'sd0) begin failed++; $display("FAIL rst_phi: got %0d want 0", phi); end
        tests++;
        if (state !== 3'd0 || rst_ctrl !== 1'b0 || ready !== 1'b0) begin
            failed++;
            $display("FAIL rst_flags: got state=%0d rst=%b rdy=%b want 0 0 0", state, rst_ctrl, ready);
        end
        tests++;
        if (mos_out !== 4'h0) begin failed++; $display("FAIL rst_mosfet: got %h want 0", mos_out); end
        step_n(2);
        #4 rst_n = 1'b1;
        step_n(1);
    endtask

    task automatic test_startup;
        th_ref = 160; ph_ref = 5; mos_in = 4'hF; en = 1'b1;
        step_n(1);
        tests++;
        if (rst_ctrl !== 1'b1 || state !== 3'd1) begin
            failed++;
            $display("FAIL pre_entry: got rst=%b state=%0d want 1 1", rst_ctrl, state);
        end
        tests++;
        if (mos_out !== 4'h0) begin failed++; $display("FAIL pre_gates: got %h want 0", mos_out); end
        step_n(7);
        tests++;
        if (state !== 3'd1 || mos_out !== 4'h0) begin
            failed++;
            $display("FAIL pre_last: got state=%0d mos=%h want 1 0", state, mos_out);
        end
        step_n(1);
        tests++;
        if (state !== 3'd2 || mos_out !== 4'hF || theta !== 32'sd170) begin
            failed++;
            $display("FAIL ramp_entry: got state=%0d mos=%h th=%0d want 2 f 170", state, mos_out, theta);
        end
        step_n(4);
        tests++;
        if (theta !== 32'sd169) begin failed++; $display("FAIL ramp_first_step: got %0d want 169", theta); end
        step_n(35);
        tests++;
        if (theta !== 32'sd161) begin failed++; $display("FAIL ramp_th39: got %0d want 161", theta); end
        step_n(1);
        tests++;
        if (theta !== 32'sd160 || phi !== 32'sd0) begin
            failed++;
            $display("FAIL ramp_th40: got th=%0d ph=%0d want 160 0", theta, phi);
        end
        step_n(20);
        tests++;
        if (phi !== 32'sd5 || state !== 3'd2 || ready !== 1'b0) begin
            failed++;
            $display("FAIL ramp_ph60: got ph=%0d state=%0d rdy=%b want 5 2 0", phi, state, ready);
        end
        step_n(1);
        tests++;
        if (state !== 3'd3 || ready !== 1'b1) begin
            failed++;
            $display("FAIL run_entry: got state=%0d rdy=%b want 3 1", state, ready);
        end
    endtask

    task automatic test_stop;
        en = 1'b0;
        step_n(1);
        tests++;
        if (state !== 3'd4 || ready !== 1'b0) begin
            failed++;
            $display("FAIL stop_entry: got state=%0d rdy=%b want 4 0", state, ready);
        end
        step_n(4);
        tests++;
        if (phi !== 32'sd4) begin failed++; $display("FAIL stop_ph4: got %0d want 4", phi); end
        step_n(16);
        tests++;
        if (phi !== 32'sd0 || theta !== 32'sd160) begin
            failed++;
            $display("FAIL stop_ph0: got ph=%0d th=%0d want 0 160", phi, theta);
        end
        step_n(4);
        tests++;
        if (theta !== 32'sd161) begin failed++; $display("FAIL stop_th161: got %0d want 161", theta); end
        step_n(36);
        tests++;
        if (theta !== 32'sd170 || state !== 3'd4) begin
            failed++;
            $display("FAIL stop_th170: got th=%0d state=%0d want 170 4", theta, state);
        end
        step_n(1);
        tests++;
        if (state !== 3'd0 || rst_ctrl !== 1'b0 || mos_out !== 4'h0) begin
            failed++;
            $display("FAIL stop_idle: got state=%0d rst=%b mos=%h want 0 0 0", state, rst_ctrl, mos_out);
        end
    endtask

    task automatic test_resume;
        th_ref = 160; ph_ref = 0; en = 1'b1;
        step_n(9);
        step_n(40);
        step_n(1);
        tests++;
        if (state !== 3'd3 || theta !== 32'sd160) begin
            failed++;
            $display("FAIL resume_run: got state=%0d th=%0d want 3 160", state, theta);
        end
        en = 1'b0;
        step_n(21);
        tests++;
        if (theta !== 32'sd165 || state !== 3'd4) begin
            failed++;
            $display("FAIL resume_stop165: got th=%0d state=%0d want 165 4", theta, state);
        end
        en = 1'b1;
        step_n(1);
        tests++;
        if (state !== 3'd2 || theta !== 32'sd165) begin
            failed++;
            $display("FAIL resume_ramp: got state=%0d th=%0d want 2 165", state, theta);
        end
        step_n(3);
        tests++;
        if (theta !== 32'sd165) begin failed++; $display("FAIL resume_hold: got %0d want 165", theta); end
        step_n(1);
        tests++;
        if (theta !== 32'sd164) begin failed++; $display("FAIL resume_step: got %0d want 164", theta); end
        step_n(17);
        tests++;
        if (state !== 3'd3 || theta !== 32'sd160) begin
            failed++;
            $display("FAIL resume_rerun: got state=%0d th=%0d want 3 160", state, theta);
        end
    endtask

    task automatic test_fault;
        mos_in = 4'b1001;
        #1;
        tests++;
        if (mos_out !== 4'b1001) begin failed++; $display("FAIL run_gates: got %b want 1001", mos_out); end
        flt = 1'b1; en = 1'b0;
        #1;
        tests++;
        if (mos_out !== 4'b0000 || state !== 3'd3) begin
            failed++;
            $display("FAIL fault_comb: got mos=%b state=%0d want 0000 3", mos_out, state);
        end
        step_n(1);
        tests++;
        if (state !== 3'd5 || theta !== 32'sd170 || phi !== 32'sd0 || rst_ctrl !== 1'b0) begin
            failed++;
            $display("FAIL fault_entry: got st=%0d th=%0d ph=%0d rst=%b want 5 170 0 0",
                     state, theta, phi, rst_ctrl);
        end
        clr = 1'b1;
        step_n(1);
        tests++;
        if (state !== 3'd5) begin failed++; $display("FAIL fault_clr_blocked: got %0d want 5", state); end
        clr = 1'b0; flt = 1'b0;
        step_n(1);
        tests++;
        if (state !== 3'd5 || mos_out !== 4'h0) begin
            failed++;
            $display("FAIL fault_sticky: got state=%0d mos=%h want 5 0", state, mos_out);
        end
        clr = 1'b1;
        step_n(1);
        clr = 1'b0;
        tests++;
        if (state !== 3'd0) begin failed++; $display("FAIL fault_clear: got %0d want 0", state); end
    endtask

    task automatic test_pre_abort;
        en = 1'b1;
        step_n(3);
        tests++;
        if (state !== 3'd1) begin failed++; $display("FAIL abort_pre: got %0d want 1", state); end
        en = 1'b0;
        step_n(1);
        tests++;
        if (state !== 3'd0 || rst_ctrl !== 1'b0) begin
            failed++;
            $display("FAIL abort_idle: got state=%0d rst=%b want 0 0", state, rst_ctrl);
        end
    endtask

    task automatic test_async_reset;
        th_ref = 160; ph_ref = 5; mos_in = 4'hF; en = 1'b1;
        step_n(9);
        step_n(28);
        tests++;
        if (theta !== 32'sd163 || state !== 3'd2) begin
            failed++;
            $display("FAIL areset_pre: got th=%0d state=%0d want 163 2", theta, state);
        end
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (theta !== 32'sd170 || state !== 3'd0) begin
            failed++;
            $display("FAIL areset_now: got th=%0d state=%0d want 170 0", theta, state);
        end
        tests++;
        if (rst_ctrl !== 1'b0 || mos_out !== 4'h0) begin
            failed++;
            $display("FAIL areset_out: got rst=%b mos=%h want 0 0", rst_ctrl, mos_out);
        end
        en = 1'b0;
        #2 rst_n = 1'b1;
        step_n(2);
        tests++;
        if (state !== 3'd0) begin failed++; $display("FAIL areset_idle: got %0d want 0", state); end
    endtask

    task automatic test_clamp;
        th_ref = 45; ph_ref = -10; en = 1'b1;
        step_n(9);
        step_n(320);
        tests++;
        if (theta !== 32'sd90 || phi !== 32'sd0) begin
            failed++;
            $display("FAIL clamp_reach: got th=%0d ph=%0d want 90 0", theta, phi);
        end
        step_n(1);
        tests++;
        if (state !== 3'd3 || ready !== 1'b1) begin
            failed++;
            $display("FAIL clamp_run: got state=%0d rdy=%b want 3 1", state, ready);
        end
        step_n(12);
        tests++;
        if (theta !== 32'sd90 || phi !== 32'sd0) begin
            failed++;
            $display("FAIL clamp_hold: got th=%0d ph=%0d want 90 0", theta, phi);
        end
    endtask

    initial begin
        tests  = 0;
        failed = 0;
        test_reset();
        test_startup();
        test_stop();
        test_resume();
        test_fault();
        test_pre_abort();
        test_async_reset();
        test_clamp();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
